// File: rtl/mem_port_arb.sv
// rtl/mem_port_arb.sv - two-master arbiter for the shared memory port with ack watchdog
// Fixed priority (M1 over M0) by default; define ARB_RR_EN for round-robin arbitration.
module mem_port_arb #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_m0_req,
  input  logic            i_m0_we,
  input  logic [AW-1:0]   i_m0_addr,
  input  logic [DW-1:0]   i_m0_wdata,
  input  logic [DW/8-1:0] i_m0_wstrb,
  output logic            o_m0_done,
  output logic            o_m0_err,
  output logic [DW-1:0]   o_m0_rdata,
  input  logic            i_m1_req,
  input  logic            i_m1_we,
  input  logic [AW-1:0]   i_m1_addr,
  input  logic [DW-1:0]   i_m1_wdata,
  input  logic [DW/8-1:0] i_m1_wstrb,
  output logic            o_m1_done,
  output logic            o_m1_err,
  output logic [DW-1:0]   o_m1_rdata,
  output logic            o_s_req,
  output logic            o_s_we,
  output logic [AW-1:0]   o_s_addr,
  output logic [DW-1:0]   o_s_wdata,
  output logic [DW/8-1:0] o_s_wstrb,
  input  logic            i_s_ack,
  input  logic [DW-1:0]   i_s_rdata,
  output logic            o_busy,
  output logic            o_owner
);

  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t      state, state_nxt;
  logic [15:0] wdog;
  logic        elig0, elig1, win, grant, ack_hit, expire;

`ifdef ARB_RR_EN
  logic rr_ptr;
`endif

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    ack_hit   = 1'b0;
    expire    = 1'b0;
    // a master is masked in its own done cycle so a still-held req is not re-granted
    elig0     = i_m0_req & ~o_m0_done;
    elig1     = i_m1_req & ~o_m1_done;
`ifdef ARB_RR_EN
    win       = (elig0 & elig1) ? ~rr_ptr : elig1;
`else
    win       = elig1;
`endif
    case (state)
      S_IDLE: begin
        if (elig0 | elig1) begin
          grant     = 1'b1;
          state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (i_s_ack) begin
          ack_hit   = 1'b1;
          state_nxt = S_IDLE;
        end else if (wdog == WDOG_LAST) begin
          expire    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  assign o_busy  = (state == S_BUSY);
  assign o_s_req = o_busy;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_owner    <= 1'b0;
      o_s_we     <= 1'b0;
      o_s_addr   <= '0;
      o_s_wdata  <= '0;
      o_s_wstrb  <= '0;
      wdog       <= '0;
      o_m0_done  <= 1'b0;
      o_m0_err   <= 1'b0;
      o_m0_rdata <= '0;
      o_m1_done  <= 1'b0;
      o_m1_err   <= 1'b0;
      o_m1_rdata <= '0;
    end else begin
      o_m0_done <= 1'b0;
      o_m0_err  <= 1'b0;
      o_m1_done <= 1'b0;
      o_m1_err  <= 1'b0;
      if (grant) begin
        o_owner   <= win;
        o_s_we    <= win ? i_m1_we    : i_m0_we;
        o_s_addr  <= win ? i_m1_addr  : i_m0_addr;
        o_s_wdata <= win ? i_m1_wdata : i_m0_wdata;
        o_s_wstrb <= win ? i_m1_wstrb : i_m0_wstrb;
        wdog      <= '0;
      end else if (o_busy) begin
        wdog <= wdog + 16'd1;
      end
      if (ack_hit | expire) begin
        if (o_owner) begin
          o_m1_done  <= 1'b1;
          o_m1_err   <= expire;
          o_m1_rdata <= (ack_hit & ~o_s_we) ? i_s_rdata : '0;
        end else begin
          o_m0_done  <= 1'b1;
          o_m0_err   <= expire;
          o_m0_rdata <= (ack_hit & ~o_s_we) ? i_s_rdata : '0;
        end
      end
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)   rr_ptr <= 1'b0;
    else if (grant) rr_ptr <= win;
  end
`endif

endmodule

// File: tb/tb_mem_port_arb.sv
// tb/tb_mem_port_arb.sv - scoreboard bench for mem_port_arb (expects ARB_RR_EN to match the DUT build)
module tb_mem_port_arb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_m0_req = 1'b0, i_m0_we = 1'b0;
  logic [AW-1:0] i_m0_addr = '0;
  logic [DW-1:0] i_m0_wdata = '0;
  logic [3:0]    i_m0_wstrb = '0;
  logic          i_m1_req = 1'b0, i_m1_we = 1'b0;
  logic [AW-1:0] i_m1_addr = '0;
  logic [DW-1:0] i_m1_wdata = '0;
  logic [3:0]    i_m1_wstrb = '0;
  logic          i_s_ack = 1'b0;
  logic [DW-1:0] i_s_rdata = '0;
  logic          o_m0_done, o_m0_err, o_m1_done, o_m1_err;
  logic [DW-1:0] o_m0_rdata, o_m1_rdata;
  logic          o_s_req, o_s_we, o_busy, o_owner;
  logic [AW-1:0] o_s_addr;
  logic [DW-1:0] o_s_wdata;
  logic [3:0]    o_s_wstrb;

  mem_port_arb #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_m0_req(i_m0_req), .i_m0_we(i_m0_we), .i_m0_addr(i_m0_addr),
    .i_m0_wdata(i_m0_wdata), .i_m0_wstrb(i_m0_wstrb),
    .o_m0_done(o_m0_done), .o_m0_err(o_m0_err), .o_m0_rdata(o_m0_rdata),
    .i_m1_req(i_m1_req), .i_m1_we(i_m1_we), .i_m1_addr(i_m1_addr),
    .i_m1_wdata(i_m1_wdata), .i_m1_wstrb(i_m1_wstrb),
    .o_m1_done(o_m1_done), .o_m1_err(o_m1_err), .o_m1_rdata(o_m1_rdata),
    .o_s_req(o_s_req), .o_s_we(o_s_we), .o_s_addr(o_s_addr),
    .o_s_wdata(o_s_wdata), .o_s_wstrb(o_s_wstrb),
    .i_s_ack(i_s_ack), .i_s_rdata(i_s_rdata),
    .o_busy(o_busy), .o_owner(o_owner)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        m;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } grant_t;

  typedef struct packed {
    logic        m;
    logic        err;
    logic [31:0] rdata;
  } cpl_t;

  grant_t gq[$];
  cpl_t   cq[$];
  grant_t g_exp;
  cpl_t   c_exp;
  logic   prev_req = 1'b0;
  int     total = 0;
  int     bad = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s: got event expected none", name);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // scoreboard monitor: grants checked on o_s_req rise, completions on done
  always @(negedge i_clk) begin
    if (o_s_req && !prev_req) begin
      if (gq.size() == 0) flag("grant_unexpected");
      else begin
        g_exp = gq.pop_front();
        check("grant_owner", 256'(o_owner), 256'(g_exp.m));
        check("grant_fields", 256'({o_s_we, o_s_addr, o_s_wdata, o_s_wstrb}),
              256'({g_exp.we, g_exp.addr, g_exp.wdata, g_exp.wstrb}));
      end
    end
    prev_req = o_s_req;
    if (o_m0_done || o_m1_done) begin
      if (cq.size() == 0) flag("done_unexpected");
      else begin
        c_exp = cq.pop_front();
        check("cpl_master", 256'({o_m1_done, o_m0_done}), 256'(c_exp.m ? 2'b10 : 2'b01));
        check("cpl_err", 256'(c_exp.m ? o_m1_err : o_m0_err), 256'(c_exp.err));
        check("cpl_rdata", 256'(c_exp.m ? o_m1_rdata : o_m0_rdata), 256'(c_exp.rdata));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1);
  end

  logic exp_win;

  initial begin
    tick(); tick();
    check("reset_outs_a", 256'({o_m0_done, o_m1_done, o_m0_err, o_m1_err, o_m0_rdata, o_m1_rdata,
                                o_s_req, o_busy, o_owner}), 256'(0));
    check("reset_outs_b", 256'({o_s_we, o_s_addr, o_s_wdata, o_s_wstrb}), 256'(0));
    i_rst_n = 1'b1;
    tick();

    // single read, M0
    i_m0_req = 1'b1; i_m0_we = 1'b0; i_m0_addr = 32'h100;
    gq.push_back('{1'b0, 1'b0, 32'h100, 32'h0, 4'h0});
    cq.push_back('{1'b0, 1'b0, 32'hDEADBEEF});
    tick();
    check("rd_sreq_c1", 256'(o_s_req), 256'(1));
    tick(); tick();
    check("rd_sreq_c3", 256'(o_s_req), 256'(1));
    i_s_ack = 1'b1; i_s_rdata = 32'hDEADBEEF;
    tick();
    i_s_ack = 1'b0; i_s_rdata = '0;
    check("rd_done", 256'({o_m0_done, o_s_req}), 256'(2'b10));
    i_m0_req = 1'b0;
    tick();
    check("rd_no_regrant", 256'(o_s_req), 256'(0));
    tick();
    check("rd_hold", 256'(o_m0_rdata), 256'(32'hDEADBEEF));

    // first contention: M1 first in both builds, M0 follows after one idle cycle
    i_m0_req = 1'b1; i_m0_addr = 32'h200;
    i_m1_req = 1'b1; i_m1_we = 1'b0; i_m1_addr = 32'h300;
    gq.push_back('{1'b1, 1'b0, 32'h300, 32'h0, 4'h0});
    gq.push_back('{1'b0, 1'b0, 32'h200, 32'h0, 4'h0});
    cq.push_back('{1'b1, 1'b0, 32'hAAAA0001});
    cq.push_back('{1'b0, 1'b0, 32'hBBBB0002});
    tick(); tick();
    i_s_ack = 1'b1; i_s_rdata = 32'hAAAA0001;
    tick();
    i_s_ack = 1'b0; i_s_rdata = '0; i_m1_req = 1'b0;
    check("cont_gap", 256'({o_m1_done, o_s_req}), 256'(2'b10));
    tick();
    check("cont_m0_rise", 256'({o_s_req, o_owner}), 256'(2'b10));
    i_s_ack = 1'b1; i_s_rdata = 32'hBBBB0002;
    tick(); tick();
    i_s_ack = 1'b0; i_s_rdata = '0; i_m0_req = 1'b0;
    tick(); tick();

    // four fresh contentions; the loser withdraws in the winner's done cycle
    for (int r = 0; r < 4; r++) begin
`ifdef ARB_RR_EN
      exp_win = (r % 2 == 0);
`else
      exp_win = 1'b1;
`endif
      i_m0_req = 1'b1; i_m0_addr = 32'h1000 + 32'(r * 16);
      i_m1_req = 1'b1; i_m1_addr = 32'h2000 + 32'(r * 16);
      gq.push_back('{exp_win, 1'b0, exp_win ? 32'h2000 + 32'(r * 16) : 32'h1000 + 32'(r * 16), 32'h0, 4'h0});
      cq.push_back('{exp_win, 1'b0, 32'hC0DE0000 + 32'(r)});
      tick();
      i_s_ack = 1'b1; i_s_rdata = 32'hC0DE0000 + 32'(r);
      tick();
      i_s_ack = 1'b0; i_s_rdata = '0;
      i_m0_req = 1'b0; i_m1_req = 1'b0;
      tick();
      check("rr_round_idle", 256'(o_s_req), 256'(0));
      tick();
    end

    // timeout: M1 write never acked, late ack ignored
    i_m1_req = 1'b1; i_m1_we = 1'b1; i_m1_addr = 32'h500; i_m1_wdata = 32'h55AA; i_m1_wstrb = 4'hF;
    gq.push_back('{1'b1, 1'b1, 32'h500, 32'h55AA, 4'hF});
    cq.push_back('{1'b1, 1'b1, 32'h0});
    tick(); tick(); tick(); tick();
    check("to_pending", 256'({o_m1_done, o_s_req}), 256'(2'b01));
    tick();
    check("to_expire", 256'({o_m1_done, o_m1_err, o_s_req}), 256'(3'b110));
    i_m1_req = 1'b0;
    tick(); tick();
    i_s_ack = 1'b1; i_s_rdata = 32'hBAD0BAD0;
    tick();
    i_s_ack = 1'b0; i_s_rdata = '0;
    check("late_ack_ignored", 256'({o_m1_done, o_busy}), 256'(0));
    tick();

    // write strobe: latched fields must ignore M1 input changes mid-transaction
    i_m1_req = 1'b1; i_m1_we = 1'b1; i_m1_addr = 32'h40; i_m1_wdata = 32'h12345678; i_m1_wstrb = 4'b0011;
    gq.push_back('{1'b1, 1'b1, 32'h40, 32'h12345678, 4'b0011});
    cq.push_back('{1'b1, 1'b0, 32'h0});
    tick();
    i_m1_we = 1'b0; i_m1_addr = 32'hFFFF; i_m1_wdata = 32'h0; i_m1_wstrb = 4'hF;
    tick(); tick();
    check("wstrb_stable", 256'({o_s_req, o_s_we, o_s_addr, o_s_wdata, o_s_wstrb}),
          256'({1'b1, 1'b1, 32'h40, 32'h12345678, 4'b0011}));
    i_s_ack = 1'b1; i_s_rdata = 32'h99999999;
    tick();
    i_s_ack = 1'b0; i_s_rdata = '0; i_m1_req = 1'b0;
    tick(); tick();

    // reset mid-BUSY abandons the transaction
    i_m0_req = 1'b1; i_m0_we = 1'b0; i_m0_addr = 32'h700;
    gq.push_back('{1'b0, 1'b0, 32'h700, 32'h0, 4'h0});
    tick(); tick();
    i_rst_n = 1'b0; i_m0_req = 1'b0;
    tick();
    check("rst_busy_a", 256'({o_m0_done, o_m1_done, o_m0_err, o_m1_err, o_m0_rdata, o_m1_rdata,
                              o_s_req, o_busy, o_owner}), 256'(0));
    check("rst_busy_b", 256'({o_s_we, o_s_addr, o_s_wdata, o_s_wstrb}), 256'(0));
    i_rst_n = 1'b1;
    tick();
    i_m0_req = 1'b1; i_m0_addr = 32'h800;
    gq.push_back('{1'b0, 1'b0, 32'h800, 32'h0, 4'h0});
    cq.push_back('{1'b0, 1'b0, 32'h13579BDF});
    tick();
    i_s_ack = 1'b1; i_s_rdata = 32'h13579BDF;
    tick();
    i_s_ack = 1'b0; i_s_rdata = '0; i_m0_req = 1'b0;
    tick(); tick(); tick();

    check("grant_q_empty", 256'(gq.size()), 256'(0));
    check("cpl_q_empty", 256'(cq.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
